spi_share_ctrl: RTL and testbench

SPI_SHARE_CTRL -- requirements
Module: spi_share_ctrl

---
 rtl/spi_share_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_share_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_share_ctrl.sv
// -----------------------------------------------------------------------------
// spi_share_ctrl
//   Shares one SPI master between N_REQ requesters (ADC plus PM DACs). Idle
//   requests are arbitrated round-robin from a rotating priority pointer. The
//   granted requester's word is shifted out MSB first (CPOL=0, CPHA=0 timing)
//   while MISO is shifted in. Each transfer is SETUP -> SHIFT -> HOLD, and each
//   phase is timed in SCLK half-periods of CLK_DIV aclk cycles.
//
// Ports
//   aclk      in   clock; every register updates on its rising edge
//   areset    in   synchronous, active-high reset
//   req       in   [N_REQ]     level requests, held until the matching done
//   req_data  in   [32*N_REQ]  shift words, slice i = [32i+31:32i]
//   req_len   in   [6*N_REQ]   bit counts 1..32 (0 and >32 mean 32)
//   gnt       out  [N_REQ]     one-hot, high for the whole granted transfer
//   done      out  [N_REQ]     one-cycle pulse in the last HOLD cycle
//   rdata     out  [32]        right-justified MISO word of the last transfer
//   busy      out              high whenever the controller is not IDLE
//   sclk      out              SPI clock, idles low
//   mosi      out              SPI data out, MSB first
//   csn       out  [N_REQ]     active-low chip selects, at most one low
//   miso      in               shared SPI data in
// -----------------------------------------------------------------------------
module spi_share_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int N_REQ   = 4
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [N_REQ-1:0]     req,
   input  logic [32*N_REQ-1:0]  req_data,
   input  logic [6*N_REQ-1:0]   req_len,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [31:0]          rdata,
   output logic                 busy,
   output logic                 sclk,
   output logic                 mosi,
   output logic [N_REQ-1:0]     csn,
   input  logic                 miso
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   // Divider value one cycle before the end of HOLD; done is registered there
   // so it shows up in the final HOLD cycle.
   localparam logic [DW-1:0] DIV_PRE  = DW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [DW-1:0]      div_q, div_d;
   logic [5:0]         bit_q, bit_d;
   logic [5:0]         len_q, len_d;
   logic               sclk_q, sclk_d;
   logic [31:0]        tx_q, tx_d;      // outgoing bits, current bit at [31]
   logic [31:0]        rx_q, rx_d;      // incoming bits, newest at [0]
   logic [IW-1:0]      sel_q, sel_d;    // granted requester
   logic [IW-1:0]      ptr_q, ptr_d;    // round-robin priority pointer
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   csn_q, csn_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [31:0]        rdata_q, rdata_d;

   // Arbitration and request-word selection
   logic               found;
   logic [IW-1:0]      pick;
   logic [IW-1:0]      idx_w;
   int                 idx;
   logic [31:0]        new_data;
   logic [5:0]         new_len;
   logic [5:0]         eff_len;
   logic [31:0]        aligned;
   logic [N_REQ-1:0]   onehot;
   logic               div_end;

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      len_d   = len_q;
      sclk_d  = sclk_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      csn_d   = csn_q;
      done_d  = '0;
      rdata_d = rdata_q;

      // First requester at or after the pointer, wrapping around.
      found = 1'b0;
      pick  = ptr_q;
      idx   = 0;
      idx_w = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_w = IW'(idx);
         if (!found && req[idx_w]) begin
            found = 1'b1;
            pick  = idx_w;
         end
      end

      new_data = '0;
      new_len  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick == IW'(k)) begin
            new_data = req_data[32*k +: 32];
            new_len  = req_len[6*k +: 6];
         end
      end

      // 0 and anything above 32 both mean a full 32-bit word.
      eff_len = ((new_len == 6'd0) || (new_len > 6'd32)) ? 6'd32 : new_len;
      // Left-align so bit len-1 sits at [31]; zeros fill in behind the word,
      // which leaves mosi low after the last bit.
      aligned = new_data << (6'd32 - eff_len);
      onehot  = '0;
      onehot[pick] = 1'b1;

      div_end = (div_q == DIV_LAST);

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = SETUP;
               sel_d   = pick;
               gnt_d   = onehot;
               csn_d   = ~onehot;
               tx_d    = aligned;
               rx_d    = '0;
               len_d   = eff_len;
               div_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
            end
         end

         SETUP: begin
            if (div_end) begin
               state_d = SHIFT;
               div_d   = '0;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[30:0], miso};   // sample on the raising edge
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         SHIFT: begin
            if (!div_end) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               if (sclk_q) begin
                  // Falling edge: present the next lower bit.
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[30:0], 1'b0};
               end else if (bit_q == len_q - 6'd1) begin
                  state_d = HOLD;
                  csn_d   = '1;
                  tx_d    = '0;
                  if (CLK_DIV == 1) begin
                     done_d  = gnt_q;
                     rdata_d = rx_q;
                  end
               end else begin
                  bit_d  = bit_q + 6'd1;
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[30:0], miso};
               end
            end
         end

         HOLD: begin
            if (div_end) begin
               state_d = IDLE;
               div_d   = '0;
               gnt_d   = '0;
               ptr_d   = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
               if (div_q == DIV_PRE) begin
                  done_d  = gnt_q;
                  rdata_d = rx_q;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge aclk) begin
      if (areset) begin
         // NOTE: the shift registers are reset too; they are small and it keeps
         // mosi and rdata free of stale data after an aborted transfer.
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         len_q   <= '0;
         sclk_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         csn_q   <= '1;
         done_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         len_q   <= len_d;
         sclk_q  <= sclk_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         csn_q   <= csn_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign busy  = (state_q != IDLE);
   assign sclk  = sclk_q;
   assign mosi  = tx_q[31];
   assign csn   = csn_q;

endmodule

// File: tb/tb_spi_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_share_ctrl
//   Directed bench for spi_share_ctrl: one instance with CLK_DIV=4 and one
//   with CLK_DIV=1. Expected values are worked out by hand from the transfer
//   timing CLK_DIV*(2+2*len) and the round-robin order.
// -----------------------------------------------------------------------------
module tb_spi_share_ctrl;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              areset;
   logic [N-1:0]      req, gnt, done, csn;
   logic [32*N-1:0]   req_data;
   logic [6*N-1:0]    req_len;
   logic [31:0]       rdata;
   logic              busy, sclk, mosi, miso;
   logic              loop_en, miso_drv;

   assign miso = loop_en ? mosi : miso_drv;

   spi_share_ctrl #(.CLK_DIV(4), .N_REQ(N)) dut (
      .aclk(clk), .areset(areset), .req(req), .req_data(req_data),
      .req_len(req_len), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .sclk(sclk), .mosi(mosi), .csn(csn), .miso(miso)
   );

   logic [N-1:0]      req1, gnt1, done1, csn1;
   logic [32*N-1:0]   req1_data;
   logic [6*N-1:0]    req1_len;
   logic [31:0]       rdata1;
   logic              busy1, sclk1, mosi1, miso1;

   assign miso1 = mosi1;

   spi_share_ctrl #(.CLK_DIV(1), .N_REQ(N)) dut1 (
      .aclk(clk), .areset(areset), .req(req1), .req_data(req1_data),
      .req_len(req1_len), .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1),
      .sclk(sclk1), .mosi(mosi1), .csn(csn1), .miso(miso1)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one transfer on dut for requester idx and measures it. drop_after>0
   // releases req[idx] once that many sclk rises have been seen.
   task automatic xfer(input int idx, input logic [31:0] data, input logic [5:0] len,
                       input int drop_after,
                       output int span, output int csn_low, output int rises,
                       output logic [31:0] mword, output logic [3:0] gval,
                       output logic ok);
      int   g_cyc;
      logic prev_sclk;
      req_data[32*idx +: 32] = data;
      req_len[6*idx +: 6]    = len;
      req[idx]               = 1'b1;
      span = 0; csn_low = 0; rises = 0; mword = '0; gval = '0; ok = 1'b0;
      g_cyc = -1;
      prev_sclk = sclk;
      for (int n = 0; n < 2000 && !ok; n++) begin
         tick();
         if (g_cyc < 0 && gnt != '0) begin
            g_cyc = n;
            gval  = gnt;
         end
         if (!csn[idx]) csn_low++;
         if (sclk && !prev_sclk) begin
            rises++;
            mword = {mword[30:0], mosi};
            if (rises == drop_after) req[idx] = 1'b0;
         end
         prev_sclk = sclk;
         if (done[idx]) begin
            ok   = 1'b1;
            span = n - g_cyc + 1;
         end
      end
      req[idx] = 1'b0;
   endtask

   int          span, csn_low, rises, last_done, dpulses, g1;
   logic [31:0] mword;
   logic [3:0]  gval;
   logic        ok, got, prev;

   initial begin
      areset = 1'b1;
      req = '0; req_data = '0; req_len = '0;
      req1 = '0; req1_data = '0; req1_len = '0;
      loop_en = 1'b0; miso_drv = 1'b0;

      // Reset, with all requests already high so the reset values must hold.
      for (int i = 0; i < N; i++) req_len[6*i +: 6] = 6'd1;
      req = 4'hF;
      tick(); tick(); tick();
      check("rst_gnt",   gnt,   0);
      check("rst_done",  done,  0);
      check("rst_busy",  busy,  0);
      check("rst_sclk",  sclk,  0);
      check("rst_mosi",  mosi,  0);
      check("rst_csn",   csn,   4'hF);
      check("rst_rdata", rdata, 0);
      check("rst_csn1",  csn1,  4'hF);

      // Contention: 0,1,2,3,0 with exactly one idle cycle before each grant.
      areset    = 1'b0;
      last_done = 0;
      for (int k = 0; k < 5; k++) begin
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            tick();
            if (gnt != '0) got = 1'b1;
         end
         check("cont_gnt_seen", got, 1);
         check("cont_order", gnt, 4'b0001 << (k % 4));
         if (k > 0) check("cont_gap", cyc - last_done, 2);
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            tick();
            if (done != '0) got = 1'b1;
         end
         check("cont_done", done, 4'b0001 << (k % 4));
         last_done = cyc;
      end
      req = '0;
      tick();
      check("cont_idle_busy", busy, 0);

      // Drop: req[2] released mid-SHIFT still completes (pointer is now 1).
      miso_drv = 1'b1;
      xfer(2, 32'h0000_00F0, 6'd8, 3, span, csn_low, rises, mword, gval, ok);
      check("drop_done",  ok,    1);
      check("drop_gnt",   gval,  4'b0100);
      check("drop_span",  span,  72);
      check("drop_rises", rises, 8);
      check("drop_rdata", rdata, 32'h0000_00FF);

      // Pointer advanced to 3: with req[0] and req[3] both up, 3 wins.
      req_len[5:0] = 6'd4;
      req[0] = 1'b1;
      xfer(3, 32'h0000_0005, 6'd4, 0, span, csn_low, rises, mword, gval, ok);
      req[0] = 1'b0;
      check("ptr_gnt",   gval,  4'b1000);
      check("ptr_rdata", rdata, 32'h0000_000F);

      // Abort: reset at the 10th sclk rise of a 32-bit transfer.
      tick();
      req_len[5:0] = 6'd0;
      req_data[31:0] = 32'hFFFF_FFFF;
      req[0] = 1'b1;
      rises = 0; got = 1'b0;
      prev = sclk;
      for (int t = 0; t < 1000 && !got; t++) begin
         tick();
         if (sclk && !prev) rises++;
         prev = sclk;
         if (rises == 10) got = 1'b1;
      end
      check("abort_reach", got, 1);
      areset = 1'b1;
      req = '0;
      tick();
      check("abort_csn",   csn,   4'hF);
      check("abort_sclk",  sclk,  0);
      check("abort_done",  done,  0);
      check("abort_rdata", rdata, 0);
      check("abort_gnt",   gnt,   0);
      tick();
      check("abort_hold_csn", csn, 4'hF);
      areset = 1'b0;
      dpulses = 0;
      for (int t = 0; t < 60; t++) begin
         tick();
         if (done != '0) dpulses++;
      end
      check("abort_no_done", dpulses, 0);

      // Single transfer: 24 bits of 0x031450 from requester 1, miso held high.
      xfer(1, 32'h0003_1450, 6'd24, 0, span, csn_low, rises, mword, gval, ok);
      check("single_done",  ok,      1);
      check("single_gnt",   gval,    4'b0010);
      check("single_span",  span,    200);
      check("single_csn",   csn_low, 196);
      check("single_rises", rises,   24);
      check("single_mosi",  mword,   32'h0003_1450);
      check("single_rdata", rdata,   32'h00FF_FFFF);
      tick();
      check("single_after_gnt",  gnt,  0);
      check("single_after_busy", busy, 0);

      // Loopback: upper bits of the word beyond len are not sent.
      loop_en = 1'b1;
      xfer(1, 32'h1234_56A5, 6'd8, 0, span, csn_low, rises, mword, gval, ok);
      check("loop_rdata", rdata, 32'h0000_00A5);
      check("loop_mosi",  mword, 32'h0000_00A5);
      check("loop_rises", rises, 8);

      // len=0 means 32 bits.
      xfer(2, 32'h8000_0001, 6'd0, 0, span, csn_low, rises, mword, gval, ok);
      check("len0_rises", rises, 32);
      check("len0_span",  span,  264);
      check("len0_rdata", rdata, 32'h8000_0001);

      // len=40 clamps to 32.
      xfer(3, 32'hDEAD_BEEF, 6'd40, 0, span, csn_low, rises, mword, gval, ok);
      check("clamp_rises", rises, 32);
      check("clamp_rdata", rdata, 32'hDEAD_BEEF);

      // CLK_DIV=1, len=1: done 4 cycles after grant, inclusive.
      req1_len[5:0]   = 6'd1;
      req1_data[31:0] = 32'h0000_0001;
      req1[0] = 1'b1;
      g1 = -1; got = 1'b0; span = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         tick();
         if (g1 < 0 && gnt1 != '0) g1 = t;
         if (done1 != '0) begin
            got  = 1'b1;
            span = t - g1 + 1;
         end
      end
      req1 = '0;
      check("div1_done",  got,    1);
      check("div1_span",  span,   4);
      check("div1_rdata", rdata1, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
